// File: rtl/function_minterm_scanner_if.sv
// Minterm index stream between the scanner and its consumer.
//   m_valid : index available (master -> slave)
//   m_ready : consumer accepts on m_valid & m_ready (slave -> master)
//   m_index : 4-bit minterm vector index (master -> slave)
//   m_last  : final minterm of the scan (master -> slave)
interface function_minterm_scanner_if;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_index;
  logic       m_last;

  modport master (output m_valid, output m_index, output m_last, input m_ready);
  modport slave  (input m_valid, input m_index, input m_last, output m_ready);
endinterface

// File: rtl/function_minterm_scanner.sv
// Sweeps all 16 input vectors of a 4-input function block, records the truth
// table of Y_cont, optionally cross-checks Y_struct, then streams the index of
// every minterm over a valid/ready handshake.
// Optional feature macro: FUNC_SCAN_CHECK_EN (Y_cont vs Y_struct comparison).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begin a scan (sampled only in IDLE)
//   busy, done        : scan in progress / one-cycle completion pulse
//   A, B, C, D        : vector driven into the function under test (A = MSB)
//   Y_cont, Y_struct  : primary / secondary function outputs
//   truth_table       : bit i = Y_cont at vector i
//   mismatch(_mask)   : Y_cont != Y_struct summary / per-vector flags
//   m                 : minterm index stream (master side)
module function_minterm_scanner #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  input  logic        Y_cont,
  input  logic        Y_struct,
  output logic [15:0] truth_table,
  output logic        mismatch,
  output logic [15:0] mismatch_mask,
  function_minterm_scanner_if.master m
);

  localparam int unsigned VEC_W   = 4;
  localparam int unsigned TBL_W   = 16;
  localparam logic [VEC_W-1:0] CNT_LAST = VEC_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] IDX_LAST = VEC_W'(TBL_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    EMIT,
    DONE
  } state_t;

  state_t             state, state_n;
  logic [VEC_W-1:0]   idx, idx_n;
  logic [VEC_W-1:0]   cnt, cnt_n;
  logic [TBL_W-1:0]   pending, pending_n;
  logic [TBL_W-1:0]   tt_q, tt_n, tt_s;
  logic [TBL_W-1:0]   mm_q, mm_n, mm_s;
  logic               mis_q, mis_n;
  logic               valid_q, valid_n;
  logic [VEC_W-1:0]   index_q, index_n;
  logic               last_q, last_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic [TBL_W-1:0]   remain;

  // Lowest set bit of a mask (priority encoder, bit 0 wins).
  function automatic logic [VEC_W-1:0] lowest_set(input logic [TBL_W-1:0] v);
    lowest_set = '0;
    for (int i = TBL_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = VEC_W'(i);
    end
  endfunction

  // True when exactly one bit of the mask is set.
  function automatic logic single_bit(input logic [TBL_W-1:0] v);
    single_bit = (v != '0) && ((v & (v - TBL_W'(1))) == '0);
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      pending <= '0;
      tt_q    <= '0;
      mm_q    <= '0;
      mis_q   <= 1'b0;
      valid_q <= 1'b0;
      index_q <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      pending <= pending_n;
      tt_q    <= tt_n;
      mm_q    <= mm_n;
      mis_q   <= mis_n;
      valid_q <= valid_n;
      index_q <= index_n;
      last_q  <= last_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    pending_n = pending;
    tt_n      = tt_q;
    mm_n      = mm_q;
    mis_n     = mis_q;
    valid_n   = valid_q;
    index_n   = index_q;
    last_n    = last_q;

    // Table contents including the vector currently being sampled.
    tt_s      = tt_q;
    tt_s[idx] = Y_cont;
    mm_s      = mm_q;
`ifdef FUNC_SCAN_CHECK_EN
    mm_s[idx] = Y_cont ^ Y_struct;
`endif
    remain    = pending & ~(TBL_W'(1) << index_q);

    case (state)
      IDLE: begin
        if (start) begin
          tt_n    = '0;
          mm_n    = '0;
          mis_n   = 1'b0;
          idx_n   = '0;
          cnt_n   = '0;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = SAMPLE;
        end else begin
          cnt_n = cnt + VEC_W'(1);
        end
      end
      SAMPLE: begin
        tt_n  = tt_s;
        mm_n  = mm_s;
        mis_n = mis_q | mm_s[idx];
        if (idx != IDX_LAST) begin
          idx_n   = idx + VEC_W'(1);
          state_n = SETTLE;
        end else if (tt_s == '0) begin
          state_n = DONE;
        end else begin
          // Outputs are registered, so the first index is prepared here.
          pending_n = tt_s;
          valid_n   = 1'b1;
          index_n   = lowest_set(tt_s);
          last_n    = single_bit(tt_s);
          state_n   = EMIT;
        end
      end
      EMIT: begin
        if (m.m_ready) begin
          pending_n = remain;
          if (remain == '0) begin
            valid_n = 1'b0;
            index_n = '0;
            last_n  = 1'b0;
            state_n = DONE;
          end else begin
            index_n = lowest_set(remain);
            last_n  = single_bit(remain);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign {A, B, C, D} = idx;
  assign truth_table  = tt_q;
  assign m.m_valid    = valid_q;
  assign m.m_index    = index_q;
  assign m.m_last     = last_q;

`ifdef FUNC_SCAN_CHECK_EN
  assign mismatch      = mis_q;
  assign mismatch_mask = mm_q;
`else
  logic unused_check;
  assign unused_check  = Y_struct ^ mis_q ^ (^mm_q);
  assign mismatch      = 1'b0;
  assign mismatch_mask = '0;
`endif

endmodule
